// File: rtl/id_ex_stage_pkg.sv
// Shared widths, the ID/EX pipeline bundle and its bubble constant.
package id_ex_stage_pkg;

  localparam int DBITS               = 32;
  localparam int REG_INDEX_BIT_WIDTH = 4;
  localparam int OP_BITS             = 8;

  typedef struct packed {
    logic                           valid;
    logic [DBITS-1:0]               pc;
    logic [OP_BITS-1:0]             op;
    logic [DBITS-1:0]               imm;
    logic [DBITS-1:0]               rs1_data;
    logic [DBITS-1:0]               rs2_data;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd;
    logic                           wrt_en;
    logic                           is_load;
  } id_ex_bundle_t;

  // All-zero control fields keep a bubble invisible to forwarding and hazard logic.
  localparam id_ex_bundle_t BUBBLE = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use detection: a decode source reads the register a load in EX will write.
module id_ex_hazard #(
  parameter int REG_INDEX_BIT_WIDTH = id_ex_stage_pkg::REG_INDEX_BIT_WIDTH
) (
  input  logic                           in_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs2,
  input  logic                           in_rs1_used,
  input  logic                           in_rs2_used,
  input  logic                           ex_valid,
  input  logic                           ex_is_load,
  input  logic                           ex_wrt_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
  output logic                           lu
);

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  // Index 0 is compared like any other register.
  always_comb begin
    load_in_ex = ex_valid & ex_is_load & ex_wrt_en;
    rs1_hit    = in_rs1_used & (in_rs1 == ex_rd);
    rs2_hit    = in_rs2_used & (in_rs2 == ex_rd);
    lu         = in_valid & load_in_ex & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, branch flush and hold.
// Optional bubble counter enabled by defining ID_EX_PERF_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DBITS               = id_ex_stage_pkg::DBITS,
  parameter int REG_INDEX_BIT_WIDTH = id_ex_stage_pkg::REG_INDEX_BIT_WIDTH,
  parameter int OP_BITS             = id_ex_stage_pkg::OP_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [DBITS-1:0]               in_pc,
  input  logic [DBITS-1:0]               in_imm,
  input  logic [OP_BITS-1:0]             in_op,
  input  logic [DBITS-1:0]               in_rs1_data,
  input  logic [DBITS-1:0]               in_rs2_data,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rd,
  input  logic                           in_rs1_used,
  input  logic                           in_rs2_used,
  input  logic                           in_wrt_en,
  input  logic                           in_is_load,
  input  logic                           flush,
  input  logic                           hold,
  output logic                           stall_out,
  output logic                           ex_valid,
  output logic                           ex_wrt_en,
  output logic                           ex_is_load,
  output logic [DBITS-1:0]               ex_pc,
  output logic [DBITS-1:0]               ex_imm,
  output logic [DBITS-1:0]               ex_rs1_data,
  output logic [DBITS-1:0]               ex_rs2_data,
  output logic [OP_BITS-1:0]             ex_op,
  output logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]                    bubble_count
`endif
);

  id_ex_bundle_t ex_q;
  id_ex_bundle_t in_bundle;
  logic          pend_flush;
  logic          lu;
  logic          kill;

  id_ex_hazard #(
    .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH)
  ) u_hazard (
    .in_valid    (in_valid),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs1_used (in_rs1_used),
    .in_rs2_used (in_rs2_used),
    .ex_valid    (ex_q.valid),
    .ex_is_load  (ex_q.is_load),
    .ex_wrt_en   (ex_q.wrt_en),
    .ex_rd       (ex_q.rd),
    .lu          (lu)
  );

  // A flushed decode slot is discarded, so it never stalls.
  always_comb begin
    kill               = flush | pend_flush;
    stall_out          = hold | (lu & ~kill);
    in_bundle          = BUBBLE;
    in_bundle.valid    = in_valid;
    in_bundle.pc       = in_pc;
    in_bundle.op       = in_op;
    in_bundle.imm      = in_imm;
    in_bundle.rs1_data = in_rs1_data;
    in_bundle.rs2_data = in_rs2_data;
    in_bundle.rd       = in_rd;
    in_bundle.wrt_en   = in_wrt_en;
    in_bundle.is_load  = in_is_load;
  end

  // A flush seen while held is remembered and applied on the first released edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= BUBBLE;
      pend_flush <= 1'b0;
    end else if (hold) begin
      pend_flush <= pend_flush | flush;
    end else if (kill) begin
      ex_q       <= BUBBLE;
      pend_flush <= 1'b0;
    end else if (lu) begin
      ex_q       <= BUBBLE;
    end else begin
      ex_q       <= in_bundle;
    end
  end

`ifdef ID_EX_PERF_EN
  // Counts bubbles from flush or load-use; saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= 32'd0;
    end else if (!hold && (kill || lu)) begin
      bubble_count <= sat_inc32(bubble_count);
    end else begin
      bubble_count <= bubble_count;
    end
  end
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_wrt_en   = ex_q.wrt_en;
  assign ex_is_load  = ex_q.is_load;
  assign ex_pc       = ex_q.pc;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_op       = ex_q.op;
  assign ex_rd       = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage; each row is one clock cycle.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [7:0]  in_op;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [3:0]  in_rd;
  logic        in_rs1_used;
  logic        in_rs2_used;
  logic        in_wrt_en;
  logic        in_is_load;
  logic        flush;
  logic        hold;
  logic        stall_out;
  logic        ex_valid;
  logic        ex_wrt_en;
  logic        ex_is_load;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [7:0]  ex_op;
  logic [3:0]  ex_rd;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count;
`endif

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .in_op       (in_op),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_rs1_used (in_rs1_used),
    .in_rs2_used (in_rs2_used),
    .in_wrt_en   (in_wrt_en),
    .in_is_load  (in_is_load),
    .flush       (flush),
    .hold        (hold),
    .stall_out   (stall_out),
    .ex_valid    (ex_valid),
    .ex_wrt_en   (ex_wrt_en),
    .ex_is_load  (ex_is_load),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_op       (ex_op),
    .ex_rd       (ex_rd)
`ifdef ID_EX_PERF_EN
    ,
    .bubble_count(bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, hld, fl, vld;
    logic [7:0]  op;
    logic [31:0] pc, rs1d;
    logic [3:0]  rs1, rs2;
    logic        rs1u, rs2u;
    logic [3:0]  rd;
    logic        wen, ld;
    logic        x_stall, x_valid;
    logic [7:0]  x_op;
    logic [31:0] x_pc, x_rs1d;
    logic [3:0]  x_rd;
    logic        x_wen, x_ld;
    logic [31:0] x_bc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int n_cmp;
  int n_fail;

  function automatic logic [31:0] imm_of(input logic [31:0] pc);
    return pc ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [31:0] swap16(input logic [31:0] v);
    return {v[15:0], v[31:16]};
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    //          rst  hld  fl   vld  op     pc            rs1d          rs1   rs2   r1u  r2u  rd    wen  ld    stall vld  op     pc            rs1d          rd    wen  ld    bc
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,4'h0,1'b0,1'b0,4'h0,1'b0,1'b0, 1'b1,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,1'b0,1'b0,32'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,8'h12,32'h0000_0100,32'hDEAD_BEEF,4'h1,4'h2,1'b1,1'b1,4'h3,1'b1,1'b0, 1'b0,1'b1,8'h12,32'h0000_0100,32'hDEAD_BEEF,4'h3,1'b1,1'b0,32'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,8'h03,32'h0000_0104,32'h0000_0000,4'h6,4'h7,1'b1,1'b1,4'h5,1'b1,1'b1, 1'b0,1'b1,8'h03,32'h0000_0104,32'h0000_0000,4'h5,1'b1,1'b1,32'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,8'h33,32'h0000_0108,32'h1111_1111,4'h1,4'h5,1'b1,1'b1,4'h8,1'b1,1'b0, 1'b1,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,1'b0,1'b0,32'd1};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,8'h33,32'h0000_0108,32'h1111_1111,4'h1,4'h5,1'b1,1'b1,4'h8,1'b1,1'b0, 1'b0,1'b1,8'h33,32'h0000_0108,32'h1111_1111,4'h8,1'b1,1'b0,32'd1};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,8'h03,32'h0000_010C,32'h0000_0000,4'h0,4'h0,1'b1,1'b1,4'h5,1'b1,1'b1, 1'b0,1'b1,8'h03,32'h0000_010C,32'h0000_0000,4'h5,1'b1,1'b1,32'd1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,8'h44,32'h0000_0110,32'h2222_2222,4'h1,4'h5,1'b1,1'b0,4'h9,1'b1,1'b0, 1'b0,1'b1,8'h44,32'h0000_0110,32'h2222_2222,4'h9,1'b1,1'b0,32'd1};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,8'h03,32'h0000_0114,32'h0000_0000,4'h0,4'h0,1'b1,1'b1,4'h2,1'b1,1'b1, 1'b0,1'b1,8'h03,32'h0000_0114,32'h0000_0000,4'h2,1'b1,1'b1,32'd1};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,8'h55,32'h0000_0118,32'h3333_3333,4'h2,4'h3,1'b1,1'b1,4'h6,1'b1,1'b0, 1'b0,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,1'b0,1'b0,32'd2};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,8'h66,32'h0000_011C,32'h4444_4444,4'h2,4'h5,1'b1,1'b1,4'h4,1'b1,1'b0, 1'b0,1'b1,8'h66,32'h0000_011C,32'h4444_4444,4'h4,1'b1,1'b0,32'd2};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h1,4'h2,1'b1,1'b1,4'h7,1'b1,1'b0, 1'b1,1'b1,8'h66,32'h0000_011C,32'h4444_4444,4'h4,1'b1,1'b0,32'd2};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h1,4'h2,1'b1,1'b1,4'h7,1'b1,1'b0, 1'b1,1'b1,8'h66,32'h0000_011C,32'h4444_4444,4'h4,1'b1,1'b0,32'd2};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h1,4'h2,1'b1,1'b1,4'h7,1'b1,1'b0, 1'b1,1'b1,8'h66,32'h0000_011C,32'h4444_4444,4'h4,1'b1,1'b0,32'd2};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h1,4'h2,1'b1,1'b1,4'h7,1'b1,1'b0, 1'b0,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,1'b0,1'b0,32'd3};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h1,4'h2,1'b1,1'b1,4'h7,1'b1,1'b0, 1'b0,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h7,1'b1,1'b0,32'd3};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b1,8'h88,32'h0000_0124,32'h6666_6666,4'h1,4'h2,1'b1,1'b1,4'h8,1'b1,1'b0, 1'b1,1'b1,8'h77,32'h0000_0120,32'h5555_5555,4'h7,1'b1,1'b0,32'd3};
    vecs[16] = '{1'b1,1'b1,1'b0,1'b1,8'h88,32'h0000_0124,32'h6666_6666,4'h1,4'h2,1'b1,1'b1,4'h8,1'b1,1'b0, 1'b1,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,1'b0,1'b0,32'd0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,8'h99,32'h0000_0200,32'h7777_7777,4'h1,4'h2,1'b1,1'b1,4'h3,1'b1,1'b0, 1'b0,1'b1,8'h99,32'h0000_0200,32'h7777_7777,4'h3,1'b1,1'b0,32'd0};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b1,8'h03,32'h0000_0204,32'h0000_0000,4'h6,4'h7,1'b1,1'b1,4'h0,1'b1,1'b1, 1'b0,1'b1,8'h03,32'h0000_0204,32'h0000_0000,4'h0,1'b1,1'b1,32'd0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,8'hAA,32'h0000_0208,32'h8888_8888,4'h0,4'h6,1'b1,1'b1,4'h9,1'b1,1'b0, 1'b1,1'b0,8'h00,32'h0000_0000,32'h0000_0000,4'h0,1'b0,1'b0,32'd1};
    vecs[20] = '{1'b0,1'b0,1'b0,1'b1,8'hAA,32'h0000_0208,32'h8888_8888,4'h0,4'h6,1'b1,1'b1,4'h9,1'b1,1'b0, 1'b0,1'b1,8'hAA,32'h0000_0208,32'h8888_8888,4'h9,1'b1,1'b0,32'd1};

    for (int i = 0; i < NV; i++) begin
      reset       = vecs[i].rst;
      hold        = vecs[i].hld;
      flush       = vecs[i].fl;
      in_valid    = vecs[i].vld;
      in_op       = vecs[i].op;
      in_pc       = vecs[i].pc;
      in_imm      = imm_of(vecs[i].pc);
      in_rs1_data = vecs[i].rs1d;
      in_rs2_data = swap16(vecs[i].rs1d);
      in_rs1      = vecs[i].rs1;
      in_rs2      = vecs[i].rs2;
      in_rs1_used = vecs[i].rs1u;
      in_rs2_used = vecs[i].rs2u;
      in_rd       = vecs[i].rd;
      in_wrt_en   = vecs[i].wen;
      in_is_load  = vecs[i].ld;
      #1;
      check("stall_out", i, {31'd0, stall_out}, {31'd0, vecs[i].x_stall});
      @(posedge clk);
      #1;
      check("ex_valid",    i, {31'd0, ex_valid},   {31'd0, vecs[i].x_valid});
      check("ex_wrt_en",   i, {31'd0, ex_wrt_en},  {31'd0, vecs[i].x_wen});
      check("ex_is_load",  i, {31'd0, ex_is_load}, {31'd0, vecs[i].x_ld});
      check("ex_op",       i, {24'd0, ex_op},      {24'd0, vecs[i].x_op});
      check("ex_rd",       i, {28'd0, ex_rd},      {28'd0, vecs[i].x_rd});
      check("ex_pc",       i, ex_pc,               vecs[i].x_pc);
      check("ex_imm",      i, ex_imm,
            (vecs[i].x_pc == 32'd0) ? 32'd0 : imm_of(vecs[i].x_pc));
      check("ex_rs1_data", i, ex_rs1_data,         vecs[i].x_rs1d);
      check("ex_rs2_data", i, ex_rs2_data,         swap16(vecs[i].x_rs1d));
`ifdef ID_EX_PERF_EN
      check("bubble_count", i, bubble_count,       vecs[i].x_bc);
`endif
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

- Pipeline register between decode and execute; clocks post-forwarding operands and control into EX.
- Owns load-use interlock:
  - Detects a decode instruction that needs a register a load currently in EX will write.
  - Inserts a one-cycle bubble and stalls decode.
- Handles branch flush from EX and a hold request from downstream, including a flush that arrives while held.

## Interface
- DBITS, 32, data/PC/immediate width
- REG_INDEX_BIT_WIDTH, 4, register index width
- OP_BITS, 8, decoded opcode width
- clk  in  1  clock; only clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode slot holds a real instruction
- in_pc, in_imm  in  DBITS each  PC, sign-extended immediate
- in_op  in  OP_BITS  decoded opcode
- in_rs1_data, in_rs2_data  in  DBITS each  forwarded operand values
- in_rs1, in_rs2, in_rd  in  REG_INDEX_BIT_WIDTH each  source/destination indices
- in_rs1_used, in_rs2_used  in  1 each  source actually read
- in_wrt_en, in_is_load  in  1 each  writes rd / is a load
- flush  in  1  EX resolved taken branch; decode slot is wrong-path
- hold  in  1  downstream busy; freeze EX
- stall_out  out  1  decode must not advance
- ex_valid, ex_wrt_en, ex_is_load  out  1 each  registered control
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  DBITS each  registered data
- ex_op  out  OP_BITS; ex_rd  out  REG_INDEX_BIT_WIDTH
- bubble_count  out  32  present only with ID_EX_PERF_EN

## Operation
- Load-use hazard (combinational), `lu` = all of:
  - in_valid & ex_valid & ex_is_load & ex_wrt_en
  - ((in_rs1_used & in_rs1==ex_rd) | (in_rs2_used & in_rs2==ex_rd))
- Internal state pend_flush (1 bit), reset 0.
- Per-edge priority, highest first:
  1. reset: all ex_* = 0, pend_flush = 0, bubble_count = 0.
  2. hold: all ex_* keep value. pend_flush <= pend_flush | flush.
  3. flush | pend_flush: load bubble (ex_valid=0, ex_wrt_en=0, ex_is_load=0; data fields don't-care, implementation zeroes them). pend_flush <= 0.
  4. lu: load bubble.
  5. else: load all in_* into ex_*; ex_valid = in_valid.
- Bubble control fields are always 0, so forwarding never matches a bubble.
- stall_out = hold | (lu & ~flush & ~pend_flush). Combinational, same cycle as the condition. A flushed decode slot is discarded, never stalled.
- Register index 0 gets no special treatment; it matches like any other index.

## Timing
- Latency 1 cycle, in_* to ex_*.
- Load-use costs exactly one bubble:
  - Cycle N: lu=1, stall_out=1.
  - Cycle N+1: EX holds the bubble; the load is in MEM, so lu=0 and the decode instruction advances.
- Flush during hold: bubble enters EX on the first edge with hold=0, even if flush is low by then.
- Flush and lu in the same cycle: one bubble, stall_out=0.
- Reset mid-hold: outputs zero next edge; pend_flush lost.
- Outputs after reset: all zero; stall_out = hold.

## Configuration
- ID_EX_PERF_EN defined:
  - bubble_count port and register exist.
  - Increments by 1 on every non-reset, non-hold edge that loads a bubble under rule 3 or 4.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package: DBITS/REG_INDEX_BIT_WIDTH/OP_BITS defaults, a packed struct for the ID/EX bundle (valid, pc, op, imm, operands, rd, wrt_en, is_load), and a BUBBLE constant of that struct.
- One sub-module, id_ex_hazard: combinational lu detection from decode sources and EX fields.

## Test plan
- No hazard: in_valid=1, in_op=8'h12, in_rs1_data=32'hDEAD_BEEF -> next edge ex_valid=1, ex_op=8'h12, ex_rs1_data=32'hDEAD_BEEF, stall_out=0.
- Load-use: EX holds load rd=5; decode rs2=5, in_rs2_used=1 -> stall_out=1; next edge ex_valid=0; following edge the decode instruction enters EX; bubble_count=1.
- Unused source: same as previous but in_rs2_used=0 -> stall_out=0, no bubble.
- Flush under hold: hold=1 for 3 cycles, flush pulses in cycle 1 -> ex_* frozen for 3 cycles, stall_out=1 throughout; first edge after hold drops gives ex_valid=0.
- Flush plus lu: both in the same cycle -> stall_out=0, one bubble, bubble_count +1.
- Reset mid-operation: reset during hold with pend_flush=1 -> next edge all ex_* = 0, bubble_count=0; first post-reset instruction loads normally.
